// File: rtl/edge_tick.sv
// Multi-channel synchronizer, optional debouncer and edge-tick generator with sticky pending flags.
// Define EDGE_TICK_DEBOUNCE_EN to compile in the per-channel debounce counters.
module edge_tick #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_sig,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_clr,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_tick,
    output logic [WIDTH-1:0] o_pend,
    output logic             o_any
);

    // Elaboration-time parameter legality checks
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("edge_tick: SYNC_STAGES must be 2..4");
    end
    if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
        $error("edge_tick: DEB_CYCLES must be 1..255");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] tick_q, tick_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] mismatch;
    logic [WIDTH-1:0] flip;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= i_sig;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign mismatch = sync_q[SYNC_STAGES-1] ^ level_q;

`ifdef EDGE_TICK_DEBOUNCE_EN
    localparam int unsigned CntW = 8;

    logic [CntW-1:0] cnt_q [WIDTH];
    logic [CntW-1:0] cnt_d [WIDTH];

    // Count consecutive mismatch edges; flip and restart once the run reaches DEB_CYCLES
    always_comb begin
        flip = '0;
        for (int c = 0; c < int'(WIDTH); c++) begin
            cnt_d[c] = '0;
            if (mismatch[c]) begin
                if (cnt_q[c] == CntW'(DEB_CYCLES - 1)) begin
                    flip[c] = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < int'(WIDTH); c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < int'(WIDTH); c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end
`else
    always_comb begin
        flip = mismatch;
    end
`endif

    // Edge qualification by mode; a new tick sets pending even if clear is requested
    always_comb begin
        level_d = level_q ^ flip;
        tick_d  = (flip & ~level_q & {WIDTH{i_mode[0]}})
                | (flip &  level_q & {WIDTH{i_mode[1]}});
        pend_d  = tick_d | (pend_q & ~i_clr);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level_q <= '0;
            tick_q  <= '0;
            pend_q  <= '0;
        end else begin
            level_q <= level_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
        end
    end

    assign o_level = level_q;
    assign o_tick  = tick_q;
    assign o_pend  = pend_q;
    assign o_any   = |pend_q;

endmodule

// File: tb/tb_edge_tick.sv
// Randomized bench for edge_tick against a window-based reference model of the filtering rules.
module tb_edge_tick;

    localparam int W    = 4;
    localparam int S    = 2;
`ifdef EDGE_TICK_DEBOUNCE_EN
    localparam int D    = 4;
`else
    localparam int D    = 1;
`endif
    localparam int NCYC = 3000;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sig;
    logic [1:0]   mode;
    logic [W-1:0] clr;
    logic [W-1:0] level, tick, pend;
    logic         any;

    always #5 clk = ~clk;

    edge_tick #(.WIDTH(W), .SYNC_STAGES(S), .DEB_CYCLES(4)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_sig   (sig),
        .i_mode  (mode),
        .i_clr   (clr),
        .o_level (level),
        .o_tick  (tick),
        .o_pend  (pend),
        .o_any   (any)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: history of sampled inputs, edge-indexed
    logic [W-1:0] rec [0:NCYC+64];
    int           n       = 0;
    int           r_last  = 0;
    int           last_ev [W];
    logic [W-1:0] m_level = '0;
    logic [W-1:0] m_tick  = '0;
    logic [W-1:0] m_pend  = '0;

    // Synchronized value seen at edge e is the input recorded S edges earlier, unless reset intervened
    function automatic logic sync_at(input int e, input int c);
        int k;
        k = e - S;
        if (k < 0 || k < r_last) return 1'b0;
        return rec[k][c];
    endfunction

    task automatic model_edge();
        logic [W-1:0] fl;
        logic         ok;
        n++;
        if (rst) begin
            rec[n]  = '0;
            r_last  = n;
            m_level = '0;
            m_tick  = '0;
            m_pend  = '0;
            for (int c = 0; c < W; c++) last_ev[c] = n;
        end else begin
            rec[n] = sig;
            fl = '0;
            for (int c = 0; c < W; c++) begin
                if (n - last_ev[c] >= D) begin
                    ok = 1'b1;
                    for (int j = 0; j < D; j++) begin
                        if (sync_at(n - j, c) == m_level[c]) ok = 1'b0;
                    end
                    if (ok) begin
                        fl[c]      = 1'b1;
                        last_ev[c] = n;
                    end
                end
            end
            m_tick  = (fl & ~m_level & {W{mode[0]}}) | (fl & m_level & {W{mode[1]}});
            m_level = m_level ^ fl;
            m_pend  = m_tick | (m_pend & ~clr);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"}, 32'(level), 32'(m_level));
        check({tag, ".tick"},  32'(tick),  32'(m_tick));
        check({tag, ".pend"},  32'(pend),  32'(m_pend));
        check({tag, ".any"},   32'(any),   32'(|m_pend));
    endtask

    initial begin
        int rst_left;
        for (int c = 0; c < W; c++) last_ev[c] = 0;
        rec[0]   = '0;
        rst      = 1'b1;
        sig      = '0;
        mode     = 2'b00;
        clr      = '0;
        rst_left = 0;

        repeat (3) begin
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        check_all("reset");

        // Held-high input through reset must be seen as a rising edge after release
        sig  = 4'b0010;
        mode = 2'b01;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all("release");
        end

        for (int i = 0; i < NCYC; i++) begin
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(0, 249) == 0) rst_left = $urandom_range(1, 3);
            rst = (rst_left > 0);
            for (int c = 0; c < W; c++) begin
                if ($urandom_range(0, 5) == 0) sig[c] = ~sig[c];
            end
            if ($urandom_range(0, 39) == 0) sig = ~sig;
            if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
            clr = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 15)) : '0;
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
